// File: rtl/pwm_music_poly.sv
// Multi-channel square-wave tone generator with a beat/phrase timebase and a single PWM mix output.
// Optional PWM_MUSIC_STACCATO_EN mutes every tone for the second half of each beat.
module pwm_music_poly #(
    parameter int CHANNELS     = 2,
    parameter int DIV_W        = 16,
    parameter int BEAT_CYCLES  = 6250000,
    parameter int PHRASE_BEATS = 16,
    parameter int PWM_W        = 8,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int BEAT_W      = (PHRASE_BEATS > 1) ? $clog2(PHRASE_BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              note_valid,
    output logic              note_ready,
    input  logic [CH_W-1:0]   note_ch,
    input  logic [DIV_W-1:0]  note_period,
    output logic              pwm,
    output logic              crotchet,
    output logic              phrase,
    output logic [BEAT_W-1:0] beat
);

    localparam int TMR_W = $clog2(BEAT_CYCLES);
    localparam int SUM_W = $clog2(CHANNELS + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(BEAT_CYCLES - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PHRASE_BEATS - 1);

    // Scale a voice count to a carrier threshold; a full chord maps to 2^PWM_W (always high).
    function automatic logic [PWM_W:0] calc_duty(input logic [SUM_W-1:0] s);
        logic [SUM_W+PWM_W-1:0] scaled;
        scaled = {s, {PWM_W{1'b0}}};
        return (PWM_W+1)'(scaled / (SUM_W+PWM_W)'(CHANNELS));
    endfunction

    logic [TMR_W-1:0] timer;
    logic             beat_edge;

    assign beat_edge = run && (timer == TMR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer    <= '0;
            beat     <= '0;
            crotchet <= 1'b0;
            phrase   <= 1'b0;
        end else begin
            crotchet <= 1'b0;
            phrase   <= 1'b0;
            if (beat_edge) begin
                timer    <= '0;
                crotchet <= 1'b1;
                if (beat == BEAT_LAST) begin
                    beat   <= '0;
                    phrase <= 1'b1;
                end else begin
                    beat <= beat + 1'b1;
                end
            end else if (run) begin
                timer <= timer + 1'b1;
            end
        end
    end

    logic [CHANNELS-1:0] pend_valid;
    logic [CHANNELS-1:0] wr_sel;
    logic [CHANNELS-1:0] xfer;
    logic [CHANNELS-1:0] sq;
    logic [DIV_W-1:0]    pend   [CHANNELS];
    logic [DIV_W-1:0]    active [CHANNELS];
    logic [DIV_W-1:0]    cnt    [CHANNELS];
    logic                pend_hit;
    logic                accept;

    // Out-of-range channel numbers match no slot, so such writes are accepted and dropped.
    always_comb begin
        pend_hit = 1'b0;
        wr_sel   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (note_ch == CH_W'(i)) begin
                pend_hit  = pend_valid[i];
                wr_sel[i] = 1'b1;
            end
        end
    end

    assign note_ready = !pend_hit || beat_edge;
    assign accept     = note_valid && note_ready;
    assign xfer       = {CHANNELS{beat_edge}} & pend_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= '0;
            sq         <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                pend[i]   <= '0;
                active[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // A write landing on the beat edge refills the slot the edge is draining.
                if (accept && wr_sel[i]) begin
                    pend[i]       <= note_period;
                    pend_valid[i] <= 1'b1;
                end else if (xfer[i]) begin
                    pend_valid[i] <= 1'b0;
                end

                if (xfer[i]) begin
                    active[i] <= pend[i];
                    cnt[i]    <= '0;
                    sq[i]     <= 1'b0;
                end else if (!run || (active[i] == '0)) begin
                    cnt[i] <= '0;
                    sq[i]  <= 1'b0;
                end else if (cnt[i] == active[i] - 1'b1) begin
                    cnt[i] <= '0;
                    sq[i]  <= ~sq[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [CHANNELS-1:0] sq_mix;
`ifdef PWM_MUSIC_STACCATO_EN
    localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(BEAT_CYCLES / 2);
    assign sq_mix = (timer >= TMR_HALF) ? '0 : sq;
`else
    assign sq_mix = sq;
`endif

    // Stage p0: voice count and carrier threshold from the registered squares.
    logic [SUM_W-1:0] sum_p0;
    logic [PWM_W:0]   duty_p0;
    logic             vld_p0;

    always_comb begin
        sum_p0 = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sum_p0 = sum_p0 + SUM_W'(sq_mix[i]);
        end
    end

    assign duty_p0 = calc_duty(sum_p0);
    assign vld_p0  = run;

    // Stage p1: registered carrier compare.
    logic [PWM_W-1:0] pwm_cnt;
    logic             pwm_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            pwm_p1  <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_p1  <= vld_p0 && ({1'b0, pwm_cnt} < duty_p0);
        end
    end

    assign pwm = pwm_p1;

endmodule

// File: tb/tb_pwm_music_poly.sv
// Directed bench for pwm_music_poly: timebase vector table plus note, backpressure, mix and reset sequences.
module tb_pwm_music_poly;

    localparam int CHANNELS     = 2;
    localparam int DIV_W        = 8;
    localparam int BEAT_CYCLES  = 16;
    localparam int PHRASE_BEATS = 4;
    localparam int PWM_W        = 4;

    logic             clk;
    logic             rst;
    logic             run;
    logic             note_valid;
    logic             note_ready;
    logic [0:0]       note_ch;
    logic [DIV_W-1:0] note_period;
    logic             pwm;
    logic             crotchet;
    logic             phrase;
    logic [1:0]       beat;

    pwm_music_poly #(
        .CHANNELS(CHANNELS), .DIV_W(DIV_W), .BEAT_CYCLES(BEAT_CYCLES),
        .PHRASE_BEATS(PHRASE_BEATS), .PWM_W(PWM_W)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .note_valid(note_valid), .note_ready(note_ready),
        .note_ch(note_ch), .note_period(note_period), .pwm(pwm), .crotchet(crotchet),
        .phrase(phrase), .beat(beat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int ncyc;
    int mtim;
    int mp [CHANNELS];
    int mt [CHANNELS];

    typedef struct {
        logic       run;
        int         cycles;
        logic       exp_crot;
        logic       exp_phr;
        logic [1:0] exp_beat;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Square level of a voice t cycles after its note started.
    function automatic int sq_at(input int t, input int p);
        if (p == 0) return 0;
        return (t / p) % 2;
    endfunction

    // One clock; the pwm registered at this edge is predicted from the voices before it.
    task automatic tick();
        int sum;
        int duty;
        int e;
        sum = 0;
        for (int c = 0; c < CHANNELS; c++) sum += sq_at(mt[c], mp[c]);
`ifdef PWM_MUSIC_STACCATO_EN
        if (mtim >= BEAT_CYCLES / 2) sum = 0;
`endif
        duty = sum * (1 << PWM_W) / CHANNELS;
        e = (run && ((ncyc % (1 << PWM_W)) < duty)) ? 1 : 0;
        @(posedge clk);
        #1;
        ncyc++;
        for (int c = 0; c < CHANNELS; c++) mt[c]++;
        if (run) mtim = (mtim + 1) % BEAT_CYCLES;
        check("pwm", 32'(pwm), 32'(e));
    endtask

    task automatic wait_crotchet(input int budget, output int n);
        n = 0;
        for (int k = 0; k < budget; k++) begin
            tick();
            n++;
            if (crotchet === 1'b1) break;
        end
        check("crotchet_seen", 32'(crotchet), 32'd1);
    endtask

    task automatic write_note(input logic [0:0] ch, input logic [DIV_W-1:0] per);
        note_valid  = 1'b1;
        note_ch     = ch;
        note_period = per;
        tick();
        note_valid  = 1'b0;
    endtask

    initial begin
        int n;
        checks = 0; failures = 0;
        ncyc = 0; mtim = 0;
        for (int c = 0; c < CHANNELS; c++) begin mp[c] = 0; mt[c] = 0; end

        tbl[0]  = '{1'b1, 15, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b1,  1, 1'b1, 1'b0, 2'd1};
        tbl[2]  = '{1'b1,  1, 1'b0, 1'b0, 2'd1};
        tbl[3]  = '{1'b1, 15, 1'b1, 1'b0, 2'd2};
        tbl[4]  = '{1'b1, 16, 1'b1, 1'b0, 2'd3};
        tbl[5]  = '{1'b1, 15, 1'b0, 1'b0, 2'd3};
        tbl[6]  = '{1'b1,  1, 1'b1, 1'b1, 2'd0};
        tbl[7]  = '{1'b1,  5, 1'b0, 1'b0, 2'd0};
        tbl[8]  = '{1'b0, 10, 1'b0, 1'b0, 2'd0};
        tbl[9]  = '{1'b1, 10, 1'b0, 1'b0, 2'd0};
        tbl[10] = '{1'b1,  1, 1'b1, 1'b0, 2'd1};

        rst = 1'b1; run = 1'b0; note_valid = 1'b0; note_ch = 1'b0; note_period = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_crotchet", 32'(crotchet), 32'd0);
        check("rst_phrase", 32'(phrase), 32'd0);
        check("rst_beat", 32'(beat), 32'd0);
        check("rst_ready", 32'(note_ready), 32'd1);
        rst = 1'b0;

        // Timebase and pause
        for (int i = 0; i < 11; i++) begin
            run = tbl[i].run;
            repeat (tbl[i].cycles) tick();
            check("tb_crotchet", 32'(crotchet), 32'(tbl[i].exp_crot));
            check("tb_phrase", 32'(phrase), 32'(tbl[i].exp_phr));
            check("tb_beat", 32'(beat), 32'(tbl[i].exp_beat));
        end

        // Deferred note: ch0 period 3 written at timer 4
        repeat (4) tick();
        note_valid = 1'b1; note_ch = 1'b0; note_period = 8'd3;
        check("ready_ch0_free", 32'(note_ready), 32'd1);
        tick();
        note_valid = 1'b0;
        check("ready_ch0_pending", 32'(note_ready), 32'd0);
        wait_crotchet(20, n);
        check("deferred_wait", 32'(n), 32'd11);
        check("beat_after_deferred", 32'(beat), 32'd2);
        mp[0] = 3; mt[0] = 0;
        check("ready_ch0_after_xfer", 32'(note_ready), 32'd1);
        repeat (12) tick();

        // Backpressure on ch1 and a write on the beat edge
        note_valid = 1'b1; note_ch = 1'b1; note_period = 8'd2;
        check("ready_ch1_first", 32'(note_ready), 32'd1);
        tick();
        note_period = 8'd5;
        check("ready_ch1_blocked", 32'(note_ready), 32'd0);
        n = 0;
        while (note_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("backpressure_wait", 32'(n), 32'd2);
        tick();
        note_valid = 1'b0;
        check("edge_write_crotchet", 32'(crotchet), 32'd1);
        mp[1] = 2; mt[1] = 0;
        check("ready_ch1_refilled", 32'(note_ready), 32'd0);
        repeat (15) tick();
        tick();
        check("second_beat_crotchet", 32'(crotchet), 32'd1);
        mp[1] = 5; mt[1] = 0;
        check("ready_ch1_drained", 32'(note_ready), 32'd1);
        repeat (8) tick();

        // Mix extremes: both period 1 in phase, then both rest
        write_note(1'b0, 8'd1);
        write_note(1'b1, 8'd1);
        wait_crotchet(20, n);
        check("mix_full_wait", 32'(n), 32'd6);
        mp[0] = 1; mt[0] = 0; mp[1] = 1; mt[1] = 0;
        tick();
        check("mix_low", 32'(pwm), 32'd0);
        tick();
        check("mix_high", 32'(pwm), 32'd1);
        repeat (6) tick();
        write_note(1'b0, 8'd0);
        write_note(1'b1, 8'd0);
        wait_crotchet(20, n);
        check("mix_rest_wait", 32'(n), 32'd6);
        mp[0] = 0; mt[0] = 0; mp[1] = 0; mt[1] = 0;
        repeat (4) tick();

        // Asynchronous reset while playing with a note pending
        write_note(1'b0, 8'd1);
        write_note(1'b1, 8'd1);
        wait_crotchet(20, n);
        check("pre_reset_wait", 32'(n), 32'd10);
        mp[0] = 1; mt[0] = 0; mp[1] = 1; mt[1] = 0;
        write_note(1'b0, 8'd7);
        tick();
        check("pre_reset_pwm", 32'(pwm), 32'd1);
        check("pre_reset_beat", 32'(beat), 32'd3);
        check("pre_reset_pending", 32'(note_ready), 32'd0);
        #2 rst = 1'b1;
        #2;
        check("async_pwm", 32'(pwm), 32'd0);
        check("async_crotchet", 32'(crotchet), 32'd0);
        check("async_beat", 32'(beat), 32'd0);
        check("async_ready", 32'(note_ready), 32'd1);
        #1 rst = 1'b0;
        ncyc = 0; mtim = 0;
        for (int c = 0; c < CHANNELS; c++) begin mp[c] = 0; mt[c] = 0; end
        wait_crotchet(40, n);
        check("post_reset_beat_len", 32'(n), 32'd16);
        check("post_reset_beat", 32'(beat), 32'd1);
        repeat (10) tick();

        // Single voice period 2 over a full beat
        write_note(1'b0, 8'd2);
        wait_crotchet(20, n);
        check("p2_wait", 32'(n), 32'd5);
        mp[0] = 2; mt[0] = 0;
        repeat (16) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
